// File: rtl/mt9p031_rx_checker.sv
`timescale 1ns/1ps
// mt9p031_rx_checker
// Receive-side checker for the MT9P031 parallel interface. It registers the
// sensor signals once and measures each frame's geometry and blanking. It also
// sums the frame's pixels and reports geometry and protocol errors. All results
// update together, one cycle after the frame closes, and then hold until the
// next frame's results replace them.
//
// Handshake: there is no valid/ready flow control. Pixel data is qualified
// only by fval&lval. o_frame_done is a single-cycle strobe. The cycle it is
// high is the first cycle that shows the new ov_*/o_*_err values.
module mt9p031_rx_checker #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fval,
  input  logic                  i_lval,
  input  logic [DATA_WIDTH-1:0] iv_pix_data,
  input  logic [CNT_WIDTH-1:0]  iv_width_exp,
  input  logic [CNT_WIDTH-1:0]  iv_height_exp,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  ov_width,
  output logic [CNT_WIDTH-1:0]  ov_height,
  output logic [CNT_WIDTH-1:0]  ov_line_hide,
  output logic [CNT_WIDTH-1:0]  ov_frame_hide,
  output logic [31:0]           ov_checksum,
  output logic [31:0]           ov_frame_cnt,
  output logic                  o_width_err,
  output logic                  o_height_err,
  output logic                  o_protocol_err
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_HIDE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam int                 PAD     = 32 - DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

  // Increment that sticks at all-ones so long frames never alias small counts.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Input stage and edge history
  logic                  fval_r_q, fval_r_d;
  logic                  lval_r_q, lval_r_d;
  logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
  logic                  in_vld_q, in_vld_d;   // input stage holds a real sample
  logic                  lval_p_q, lval_p_d;   // lval_r one cycle earlier

  // Capture state
  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  hide_cnt_q, hide_cnt_d;
  logic [CNT_WIDTH-1:0]  fhide_pend_q, fhide_pend_d;
  logic [CNT_WIDTH-1:0]  width_exp_q, width_exp_d;
  logic [CNT_WIDTH-1:0]  height_exp_q, height_exp_d;
  logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]  last_w_q, last_w_d;
  logic [CNT_WIDTH-1:0]  line_hide_q, line_hide_d;
  logic [31:0]           csum_q, csum_d;
  logic                  werr_q, werr_d;
  logic                  prot_q, prot_d;
  logic                  done_pend_q, done_pend_d;

  // Published results
  logic                  frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0]  width_o_q, width_o_d;
  logic [CNT_WIDTH-1:0]  height_o_q, height_o_d;
  logic [CNT_WIDTH-1:0]  lhide_o_q, lhide_o_d;
  logic [CNT_WIDTH-1:0]  fhide_o_q, fhide_o_d;
  logic [31:0]           csum_o_q, csum_o_d;
  logic [31:0]           fcnt_q, fcnt_d;
  logic                  werr_o_q, werr_o_d;
  logic                  herr_o_q, herr_o_d;
  logic                  perr_o_q, perr_o_d;

  // Next-state logic: publish pending results, track protocol, run the capture FSM.
  always_comb begin
    fval_r_d     = i_fval;
    lval_r_d     = i_lval;
    data_r_d     = iv_pix_data;
    in_vld_d     = 1'b1;
    lval_p_d     = lval_r_q;
    state_d      = state_q;
    hide_cnt_d   = hide_cnt_q;
    fhide_pend_d = fhide_pend_q;
    width_exp_d  = width_exp_q;
    height_exp_d = height_exp_q;
    pix_cnt_d    = pix_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    line_cnt_d   = line_cnt_q;
    last_w_d     = last_w_q;
    line_hide_d  = line_hide_q;
    csum_d       = csum_q;
    werr_d       = werr_q;
    prot_d       = prot_q;
    done_pend_d  = 1'b0;
    frame_done_d = 1'b0;
    width_o_d    = width_o_q;
    height_o_d   = height_o_q;
    lhide_o_d    = lhide_o_q;
    fhide_o_d    = fhide_o_q;
    csum_o_d     = csum_o_q;
    fcnt_d       = fcnt_q;
    werr_o_d     = werr_o_q;
    herr_o_d     = herr_o_q;
    perr_o_d     = perr_o_q;

    // Results of the frame closed last cycle go out together.
    if (done_pend_q) begin
      frame_done_d = 1'b1;
      width_o_d    = last_w_q;
      height_o_d   = line_cnt_q;
      lhide_o_d    = line_hide_q;
      fhide_o_d    = fhide_pend_q;
      csum_o_d     = csum_q;
      fcnt_d       = fcnt_q + 32'd1;
      werr_o_d     = werr_q;
      herr_o_d     = (line_cnt_q != height_exp_q);
      perr_o_d     = prot_q;
      prot_d       = 1'b0;
    end

    // A line outside a frame is a violation wherever the FSM is locked.
    if (state_q != ST_SYNC && lval_r_q && !fval_r_q) begin
      prot_d = 1'b1;
    end

    case (state_q)
      ST_SYNC: begin
        // Wait out any frame already in flight when reset was released.
        if (in_vld_q && !fval_r_q) begin
          state_d    = ST_HIDE;
          hide_cnt_d = CNT_ONE;
        end
      end
      ST_HIDE: begin
        if (fval_r_q) begin
          state_d      = ST_ACTIVE;
          width_exp_d  = iv_width_exp;
          height_exp_d = iv_height_exp;
          fhide_pend_d = hide_cnt_q;
          line_cnt_d   = CNT_ZERO;
          csum_d       = 32'd0;
          werr_d       = 1'b0;
          last_w_d     = CNT_ZERO;
          line_hide_d  = CNT_ZERO;
          pix_cnt_d    = CNT_ZERO;
          gap_cnt_d    = CNT_ZERO;
        end else begin
          hide_cnt_d = sat_inc(hide_cnt_q);
        end
      end
      ST_ACTIVE: begin
        if (!fval_r_q) begin
          // Frame end; a line still open is closed and flagged.
          if (lval_p_q) begin
            line_cnt_d = sat_inc(line_cnt_q);
            last_w_d   = pix_cnt_q;
            if (pix_cnt_q != width_exp_q) werr_d = 1'b1;
            prot_d     = 1'b1;
          end
          state_d     = ST_HIDE;
          hide_cnt_d  = CNT_ONE;
          done_pend_d = 1'b1;
        end else if (lval_r_q) begin
          if (!lval_p_q) begin
            pix_cnt_d = CNT_ONE;
            if (line_cnt_q != CNT_ZERO) line_hide_d = gap_cnt_q;
          end else begin
            pix_cnt_d = sat_inc(pix_cnt_q);
          end
          csum_d = csum_q + {{PAD{1'b0}}, data_r_q};
        end else if (lval_p_q) begin
          line_cnt_d = sat_inc(line_cnt_q);
          last_w_d   = pix_cnt_q;
          if (pix_cnt_q != width_exp_q) werr_d = 1'b1;
          gap_cnt_d  = CNT_ONE;
        end else begin
          gap_cnt_d = sat_inc(gap_cnt_q);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_r_q     <= 1'b0;
      lval_r_q     <= 1'b0;
      data_r_q     <= '0;
      in_vld_q     <= 1'b0;
      lval_p_q     <= 1'b0;
      state_q      <= ST_SYNC;
      hide_cnt_q   <= '0;
      fhide_pend_q <= '0;
      width_exp_q  <= '0;
      height_exp_q <= '0;
      pix_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      line_cnt_q   <= '0;
      last_w_q     <= '0;
      line_hide_q  <= '0;
      csum_q       <= '0;
      werr_q       <= 1'b0;
      prot_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      width_o_q    <= '0;
      height_o_q   <= '0;
      lhide_o_q    <= '0;
      fhide_o_q    <= '0;
      csum_o_q     <= '0;
      fcnt_q       <= '0;
      werr_o_q     <= 1'b0;
      herr_o_q     <= 1'b0;
      perr_o_q     <= 1'b0;
    end else begin
      fval_r_q     <= fval_r_d;
      lval_r_q     <= lval_r_d;
      data_r_q     <= data_r_d;
      in_vld_q     <= in_vld_d;
      lval_p_q     <= lval_p_d;
      state_q      <= state_d;
      hide_cnt_q   <= hide_cnt_d;
      fhide_pend_q <= fhide_pend_d;
      width_exp_q  <= width_exp_d;
      height_exp_q <= height_exp_d;
      pix_cnt_q    <= pix_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      line_cnt_q   <= line_cnt_d;
      last_w_q     <= last_w_d;
      line_hide_q  <= line_hide_d;
      csum_q       <= csum_d;
      werr_q       <= werr_d;
      prot_q       <= prot_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      width_o_q    <= width_o_d;
      height_o_q   <= height_o_d;
      lhide_o_q    <= lhide_o_d;
      fhide_o_q    <= fhide_o_d;
      csum_o_q     <= csum_o_d;
      fcnt_q       <= fcnt_d;
      werr_o_q     <= werr_o_d;
      herr_o_q     <= herr_o_d;
      perr_o_q     <= perr_o_d;
    end
  end

  assign o_frame_done   = frame_done_q;
  assign ov_width       = width_o_q;
  assign ov_height      = height_o_q;
  assign ov_line_hide   = lhide_o_q;
  assign ov_frame_hide  = fhide_o_q;
  assign ov_checksum    = csum_o_q;
  assign ov_frame_cnt   = fcnt_q;
  assign o_width_err    = werr_o_q;
  assign o_height_err   = herr_o_q;
  assign o_protocol_err = perr_o_q;

endmodule

// File: tb/tb_mt9p031_rx_checker.sv
`timescale 1ns/1ps
// Directed bench for mt9p031_rx_checker: drives frames of known geometry and
// compares the published per-frame results against hand-computed values.
module tb_mt9p031_rx_checker;
  localparam int DW = 12;
  localparam int CW = 16;

  // Clock and reset
  logic          clk = 1'b0;
  logic          reset;
  logic          i_fval;
  logic          i_lval;
  logic [DW-1:0] iv_pix_data;
  logic [CW-1:0] iv_width_exp;
  logic [CW-1:0] iv_height_exp;
  logic          o_frame_done;
  logic [CW-1:0] ov_width;
  logic [CW-1:0] ov_height;
  logic [CW-1:0] ov_line_hide;
  logic [CW-1:0] ov_frame_hide;
  logic [31:0]   ov_checksum;
  logic [31:0]   ov_frame_cnt;
  logic          o_width_err;
  logic          o_height_err;
  logic          o_protocol_err;

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_seen    = 0;
  int done_mark;
  int pix_idx;

  mt9p031_rx_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(iv_pix_data), .iv_width_exp(iv_width_exp), .iv_height_exp(iv_height_exp),
    .o_frame_done(o_frame_done), .ov_width(ov_width), .ov_height(ov_height),
    .ov_line_hide(ov_line_hide), .ov_frame_hide(ov_frame_hide), .ov_checksum(ov_checksum),
    .ov_frame_cnt(ov_frame_cnt), .o_width_err(o_width_err), .o_height_err(o_height_err),
    .o_protocol_err(o_protocol_err)
  );

  // Count frame_done strobes away from the active edge.
  always @(negedge clk) if (o_frame_done === 1'b1) done_seen++;

  // Overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int lh,
                             input int fh, input logic [31:0] cs, input int fc,
                             input bit we, input bit he, input bit pe);
    check({tag, " width"},      32'(ov_width),       32'(w));
    check({tag, " height"},     32'(ov_height),      32'(h));
    check({tag, " line_hide"},  32'(ov_line_hide),   32'(lh));
    check({tag, " frame_hide"}, 32'(ov_frame_hide),  32'(fh));
    check({tag, " checksum"},   ov_checksum,         cs);
    check({tag, " frame_cnt"},  ov_frame_cnt,        32'(fc));
    check({tag, " width_err"},  32'(o_width_err),    32'(we));
    check({tag, " height_err"}, 32'(o_height_err),   32'(he));
    check({tag, " prot_err"},   32'(o_protocol_err), 32'(pe));
  endtask

  // Driver tasks: each cycle() presents one sample and returns at the next negedge.
  task automatic cycle(input logic f, input logic l, input logic [DW-1:0] d);
    i_fval = f; i_lval = l; iv_pix_data = d;
    @(negedge clk);
  endtask

  task automatic hide(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      if (pulse_at >= 0 && i >= pulse_at && i < pulse_at + 3) cycle(1'b0, 1'b1, 12'd100);
      else cycle(1'b0, 1'b0, '0);
    end
  endtask

  task automatic line(input int w);
    for (int i = 0; i < w; i++) begin
      cycle(1'b1, 1'b1, pix_idx[DW-1:0]);
      pix_idx++;
    end
  endtask

  // 5-cycle line gaps, data = running pixel index; drop ends the frame mid-line.
  task automatic drive_frame(input int n_lines, input int bad_line, input int bad_w, input bit drop);
    pix_idx = 0;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    for (int l = 0; l < n_lines; l++) begin
      line((l == bad_line) ? bad_w : 8);
      if (l == n_lines - 1) begin
        if (!drop) begin
          cycle(1'b1, 1'b0, '0);
          cycle(1'b1, 1'b0, '0);
        end
      end else begin
        repeat (5) cycle(1'b1, 1'b0, '0);
      end
    end
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; i_fval = 1'b0; i_lval = 1'b0; iv_pix_data = '0;
    iv_width_exp = 16'd8; iv_height_exp = 16'd4;
    repeat (3) @(negedge clk);
    check("reset frame_done", 32'(o_frame_done), 32'd0);
    check_frame("reset", 0, 0, 0, 0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Clean 8x4 frame with latency check on the trailing blanking
    hide(20, -1);
    drive_frame(4, -1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, '0);
      if (i == 1) check("latency done early", 32'(o_frame_done), 32'd0);
      if (i == 2) check("latency done pulse", 32'(o_frame_done), 32'd1);
      if (i == 3) check("latency done width", 32'(o_frame_done), 32'd0);
    end
    check_frame("clean1", 8, 4, 5, 20, 32'd496, 1, 1'b0, 1'b0, 1'b0);
    check("clean1 done count", 32'(done_seen), 32'd1);

    // Second line short by one pixel
    drive_frame(4, 1, 7, 1'b0);
    hide(20, -1);
    check_frame("short_line", 8, 4, 5, 20, 32'd465, 2, 1'b1, 1'b0, 1'b0);

    // Clean frame clears the width error
    drive_frame(4, -1, 0, 1'b0);
    hide(20, -1);
    check_frame("clean2", 8, 4, 5, 20, 32'd496, 3, 1'b0, 1'b0, 1'b0);

    // Three lines against an expected four; stray lval pulse in the following blanking
    drive_frame(3, -1, 0, 1'b0);
    hide(20, 8);
    check_frame("three_lines", 8, 3, 5, 20, 32'd276, 4, 1'b0, 1'b1, 1'b0);

    // Pulse is reported with the next frame, its pixels not summed
    drive_frame(4, -1, 0, 1'b0);
    hide(20, -1);
    check_frame("stray_lval", 8, 4, 5, 20, 32'd496, 5, 1'b0, 1'b0, 1'b1);

    // fval and lval drop together after 4 pixels of the fourth line
    drive_frame(4, 3, 4, 1'b1);
    hide(20, -1);
    check_frame("fval_drop", 4, 4, 5, 20, 32'd378, 6, 1'b1, 1'b0, 1'b1);

    drive_frame(4, -1, 0, 1'b0);
    hide(20, -1);
    check_frame("clean3", 8, 4, 5, 20, 32'd496, 7, 1'b0, 1'b0, 1'b0);

    // Reset pulsed and released in the middle of a frame
    done_mark = done_seen;
    pix_idx = 0;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    line(8);
    cycle(1'b1, 1'b0, '0);
    reset = 1'b1;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    reset = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, '0);
    line(8);
    repeat (5) cycle(1'b1, 1'b0, '0);
    line(8);
    cycle(1'b1, 1'b0, '0);
    hide(20, -1);
    check("partial no done", 32'(done_seen - done_mark), 32'd0);
    check("partial frame_cnt", ov_frame_cnt, 32'd0);
    check("partial height", 32'(ov_height), 32'd0);

    drive_frame(4, -1, 0, 1'b0);
    hide(20, -1);
    drive_frame(4, -1, 0, 1'b0);
    hide(20, -1);
    check_frame("post_reset", 8, 4, 5, 20, 32'd496, 2, 1'b0, 1'b0, 1'b0);
    check("post_reset done count", 32'(done_seen - done_mark), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
